// File: rtl/free_list_mw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : free_list_pkg
// Purpose  : Shared constants and lane-compaction helpers for the multi-width
//            physical-register free list.
// Contents : PHYSREG_DEF, AREG_DEF  - default geometry
//            popcount()             - number of set bits in a 4-bit lane mask
//            lane_offset()          - compacted slot of lane j in a lane mask
// Revision : 1.0  initial release
// ============================================================================
package free_list_pkg;

  localparam int PHYSREG_DEF = 128;
  localparam int AREG_DEF    = 32;

  function automatic logic [2:0] popcount(input logic [3:0] mask);
    popcount = '0;
    for (int i = 0; i < 4; i++) begin
      popcount = popcount + 3'(mask[i]);
    end
  endfunction

  // Lane j lands after every valid lane below it.
  function automatic logic [2:0] lane_offset(input logic [3:0] mask, input int lane);
    lane_offset = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < lane) begin
        lane_offset = lane_offset + 3'(mask[i]);
      end
    end
  endfunction

endpackage : free_list_pkg
`default_nettype wire

// File: rtl/free_list_mw_if.sv
`default_nettype none
// ============================================================================
// Module   : free_list_mw_if
// Purpose  : Rename-stage handshake bundle for the free list.
// Ports    : alloc_req_i/alloc_gnt_o/alloc_preg_o  - allocation lanes
//            free_valid_i/free_preg_i              - retire-side free lanes
//            free_count_o/empty_o/full_o           - occupancy status
//            chkpt_head_o/recover_i/recover_head_i - branch checkpoint/restore
//            overflow_o                            - sticky dropped-free flag
//            modport slave : the free list; modport master : the rename stage
// Revision : 1.0  initial release
// ============================================================================
interface free_list_mw_if
  import free_list_pkg::*;
#(
  parameter int PHYSREG = PHYSREG_DEF,
  parameter int ALLOC_W = 2,
  parameter int FREE_W  = 2
);
  localparam int PW = $clog2(PHYSREG);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(ALLOC_W + 1);

  logic [RW-1:0]               alloc_req_i;
  logic                        alloc_gnt_o;
  logic [ALLOC_W-1:0][PW-1:0]  alloc_preg_o;
  logic [FREE_W-1:0]           free_valid_i;
  logic [FREE_W-1:0][PW-1:0]   free_preg_i;
  logic [CW-1:0]               free_count_o;
  logic                        empty_o;
  logic                        full_o;
  logic [CW-1:0]               chkpt_head_o;
  logic                        recover_i;
  logic [CW-1:0]               recover_head_i;
  logic                        overflow_o;

  modport slave (
    input  alloc_req_i, free_valid_i, free_preg_i, recover_i, recover_head_i,
    output alloc_gnt_o, alloc_preg_o, free_count_o, empty_o, full_o,
           chkpt_head_o, overflow_o
  );

  modport master (
    output alloc_req_i, free_valid_i, free_preg_i, recover_i, recover_head_i,
    input  alloc_gnt_o, alloc_preg_o, free_count_o, empty_o, full_o,
           chkpt_head_o, overflow_o
  );

endinterface : free_list_mw_if
`default_nettype wire

// File: rtl/free_list_mw_compact.sv
`default_nettype none
// ============================================================================
// Module   : free_list_compact
// Purpose  : Prefix-sum over the free strobes. Packs valid lanes into
//            consecutive slots and accepts them in lane order while room lasts.
// Ports    : valid    in  per-lane free strobes
//            room     in  slots available after this cycle's allocation
//            offset   out compacted slot of each lane
//            accept   out lanes that will be written
//            n_accept out number of accepted lanes
//            dropped  out some valid lane did not fit
// Revision : 1.0  initial release
// ============================================================================
module free_list_compact
  import free_list_pkg::*;
#(
  parameter int FREE_W = 2,
  parameter int CW     = 8
) (
  input  logic [FREE_W-1:0]      valid,
  input  logic [CW-1:0]          room,
  output logic [FREE_W-1:0][2:0] offset,
  output logic [FREE_W-1:0]      accept,
  output logic [2:0]             n_accept,
  output logic                   dropped
);

  logic [3:0] vpad;

  always_comb begin
    vpad = 4'(valid);
    for (int j = 0; j < FREE_W; j++) begin
      offset[j] = lane_offset(vpad, j);
      // Slots are handed out in lane order, so a lane fits iff its slot < room.
      accept[j] = valid[j] && (CW'(offset[j]) < room);
    end
    n_accept = popcount(4'(accept));
    dropped  = |(valid & ~accept);
  end

endmodule : free_list_compact
`default_nettype wire

// File: rtl/free_list_mw.sv
`default_nettype none
// ============================================================================
// Module   : free_list_mw
// Purpose  : Circular-buffer free list of physical-register indices with
//            ALLOC_W all-or-nothing allocation lanes, FREE_W free lanes,
//            head checkpointing and mispredict recovery.
// Ports    : clk_i  in  clock
//            rst_i  in  asynchronous active-high reset
//            bus    slave modport of free_list_mw_if (see interface header)
// Revision : 1.0  initial release
// ============================================================================
module free_list_mw
  import free_list_pkg::*;
#(
  parameter int PHYSREG = PHYSREG_DEF,
  parameter int AREG    = AREG_DEF,
  parameter int ALLOC_W = 2,
  parameter int FREE_W  = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  free_list_mw_if.slave  bus
);

  localparam int PW = $clog2(PHYSREG);
  localparam int CW = PW + 1;

  logic [CW-1:0] head, tail, count, req_ext, granted, head_next, room;
  logic          gnt, overflow, dropped;
  logic [2:0]    n_accept;
  logic [FREE_W-1:0][2:0]    offset;
  logic [FREE_W-1:0]         accept;
  logic [FREE_W-1:0][PW-1:0] waddr;
  logic [PW-1:0]             mem [PHYSREG];

  // Pointers carry a wrap bit, so the difference is the occupancy directly.
  assign count     = tail - head;
  assign req_ext   = CW'(bus.alloc_req_i);
  assign gnt       = (bus.alloc_req_i != '0) && (count >= req_ext) && !bus.recover_i;
  assign granted   = gnt ? req_ext : '0;
  assign head_next = bus.recover_i ? bus.recover_head_i : head + granted;
  // Room is measured against the head that will exist next cycle, so a
  // recovery that un-allocates entries also shrinks the room for frees.
  assign room      = CW'(PHYSREG) - (tail - head_next);

  free_list_compact #(
    .FREE_W (FREE_W),
    .CW     (CW)
  ) u_compact (
    .valid    (bus.free_valid_i),
    .room     (room),
    .offset   (offset),
    .accept   (accept),
    .n_accept (n_accept),
    .dropped  (dropped)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head     <= '0;
      tail     <= CW'(PHYSREG - AREG);
      overflow <= 1'b0;
    end else begin
      head <= head_next;
      tail <= tail + CW'(n_accept);
      if (dropped) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < FREE_W; j++) begin
      waddr[j] = tail[PW-1:0] + PW'(offset[j]);
    end
  end

  // One register per entry so each reset value is a per-entry constant.
  for (genvar i = 0; i < PHYSREG; i++) begin : g_mem
    localparam logic [PW-1:0] RST_VAL = (i < PHYSREG - AREG) ? PW'(AREG + i) : '0;
    logic          hit;
    logic [PW-1:0] wdata;

    always_comb begin
      hit   = 1'b0;
      wdata = mem[i];
      for (int j = 0; j < FREE_W; j++) begin
        if (accept[j] && (waddr[j] == PW'(i))) begin
          hit   = 1'b1;
          wdata = bus.free_preg_i[j];
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mem[i] <= RST_VAL;
      end else if (hit) begin
        mem[i] <= wdata;
      end
    end
  end

  for (genvar k = 0; k < ALLOC_W; k++) begin : g_rd
    assign bus.alloc_preg_o[k] = mem[head[PW-1:0] + PW'(k)];
  end

  assign bus.alloc_gnt_o  = gnt;
  assign bus.free_count_o = count;
  assign bus.empty_o      = (count == '0);
  assign bus.full_o       = (count == CW'(PHYSREG));
  assign bus.chkpt_head_o = head;
  assign bus.overflow_o   = overflow;

endmodule : free_list_mw
`default_nettype wire

// File: tb/tb_free_list_mw.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list_mw
// Purpose  : Directed, scoreboard-checked bench for free_list_mw
//            (PHYSREG=128, AREG=32, ALLOC_W=2, FREE_W=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_free_list_mw;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  free_list_mw_if #(.PHYSREG(128), .ALLOC_W(2), .FREE_W(2)) bus ();

  free_list_mw #(
    .PHYSREG (128),
    .AREG    (32),
    .ALLOC_W (2),
    .FREE_W  (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // -1 in a field means "not checked this cycle".
  typedef struct {
    string nm;
    int g, p0, p1, cnt, hd, em, fu, ov;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input int g, input int p0, input int p1,
                          input int cnt, input int hd, input int em, input int fu,
                          input int ov);
    exp_t e;
    e.nm = nm; e.g = g; e.p0 = p0; e.p1 = p1; e.cnt = cnt;
    e.hd = hd; e.em = em; e.fu = fu; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic cyc(input int req, input logic [1:0] fv, input int f0, input int f1,
                     input bit rec, input int rh);
    @(posedge clk);
    #1;
    bus.alloc_req_i    = 2'(req);
    bus.free_valid_i   = fv;
    bus.free_preg_i[0] = 7'(f0);
    bus.free_preg_i[1] = 7'(f1);
    bus.recover_i      = rec;
    bus.recover_head_i = 8'(rh);
  endtask

  task automatic idle();
    cyc(0, 2'b00, 0, 0, 1'b0, 0);
  endtask

  // Monitor: compares every pending expectation against the outputs the DUT
  // presents mid-cycle, plus the standing occupancy/recovery-range properties.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.g   >= 0) check({e.nm, ".gnt"},   32'(bus.alloc_gnt_o),     e.g);
      if (e.p0  >= 0) check({e.nm, ".preg0"}, 32'(bus.alloc_preg_o[0]), e.p0);
      if (e.p1  >= 0) check({e.nm, ".preg1"}, 32'(bus.alloc_preg_o[1]), e.p1);
      if (e.cnt >= 0) check({e.nm, ".count"}, 32'(bus.free_count_o),    e.cnt);
      if (e.hd  >= 0) check({e.nm, ".head"},  32'(bus.chkpt_head_o),    e.hd);
      if (e.em  >= 0) check({e.nm, ".empty"}, 32'(bus.empty_o),         e.em);
      if (e.fu  >= 0) check({e.nm, ".full"},  32'(bus.full_o),          e.fu);
      if (e.ov  >= 0) check({e.nm, ".ovf"},   32'(bus.overflow_o),      e.ov);
    end
    if (!rst) begin
      check("count_bound", 32'(bus.free_count_o <= 8'd128), 1);
      if (bus.recover_i) begin
        check("recover_range",
              32'(8'(bus.chkpt_head_o + bus.free_count_o - bus.recover_head_i) <= 8'd128), 1);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.alloc_req_i    = '0;
    bus.free_valid_i   = '0;
    bus.free_preg_i    = '0;
    bus.recover_i      = 1'b0;
    bus.recover_head_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_exp("reset", 0, 32, 33, 96, 0, 0, 0, 0);

    // Drain with two-wide allocations: indices 32..125.
    for (int i = 0; i < 47; i++) begin
      cyc(2, 2'b00, 0, 0, 1'b0, 0);
      push_exp("alloc2", 1, 32 + 2*i, 33 + 2*i, 96 - 2*i, 2*i, 0, 0, -1);
    end
    cyc(1, 2'b00, 0, 0, 1'b0, 0);
    push_exp("alloc1_126", 1, 126, -1, 2, 94, 0, -1, -1);
    cyc(2, 2'b00, 0, 0, 1'b0, 0);
    push_exp("short_req", 0, 127, -1, 1, 95, 0, -1, -1);
    cyc(1, 2'b00, 0, 0, 1'b0, 0);
    push_exp("alloc1_127", 1, 127, -1, 1, 95, -1, -1, -1);
    cyc(1, 2'b00, 0, 0, 1'b0, 0);
    push_exp("empty_req", 0, -1, -1, 0, 96, 1, 0, -1);

    // Frees are invisible to allocation in the cycle they arrive.
    cyc(1, 2'b11, 5, 9, 1'b0, 0);
    push_exp("free_same_cyc", 0, -1, -1, 0, 96, 1, -1, -1);
    idle();
    push_exp("freed_visible", 0, 5, 9, 2, 96, 0, -1, -1);

    // Fresh reset, then checkpoint / allocate / recover.
    idle();
    rst = 1'b1;
    push_exp("rst2", 0, 32, 33, 96, 0, 0, 0, 0);
    idle();
    rst = 1'b0;
    push_exp("chkpt", 0, -1, -1, 96, 0, -1, -1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(2, 2'b00, 0, 0, 1'b0, 0);
      push_exp("spec_alloc", 1, 32 + 2*i, 33 + 2*i, 96 - 2*i, 2*i, -1, -1, -1);
    end
    cyc(2, 2'b01, 7, 0, 1'b1, 0);
    push_exp("recover_cyc", 0, -1, -1, 86, 10, -1, -1, -1);
    idle();
    push_exp("recovered", 0, 32, 33, 97, 0, 0, 0, 0);

    // Fill toward full.
    for (int i = 0; i < 15; i++) begin
      cyc(0, 2'b11, 70 + i, 90 + i, 1'b0, 0);
      push_exp("fill", -1, -1, -1, 97 + 2*i, 0, -1, 0, 0);
    end
    cyc(0, 2'b11, 50, 51, 1'b0, 0);
    push_exp("partial_free", -1, -1, -1, 127, 0, -1, 0, 0);
    cyc(2, 2'b11, 60, 61, 1'b0, 0);
    push_exp("full_alloc_free", 1, 32, 33, 128, 0, 0, 1, 1);
    cyc(0, 2'b11, 1, 2, 1'b0, 0);
    push_exp("full_drop", -1, -1, -1, 128, 2, -1, 1, 1);
    idle();
    push_exp("drop_sticky", -1, -1, -1, 128, 2, 0, 1, 1);

    // Drain across the wrap and look at the entries written there.
    for (int i = 0; i < 63; i++) begin
      cyc(2, 2'b00, 0, 0, 1'b0, 0);
      push_exp("drain", 1, -1, -1, 128 - 2*i, 2 + 2*i, -1, -1, 1);
      if (i == 47) push_exp("drain_mid", -1, 7, 70, -1, -1, -1, -1, -1);
    end
    idle();
    push_exp("wrapped", 0, 60, 61, 2, 128, 0, 0, 1);

    // Reset in the middle of a busy cycle wins over everything.
    cyc(2, 2'b11, 3, 4, 1'b1, 128);
    rst = 1'b1;
    push_exp("mid_rst", 0, 32, 33, 96, 0, 0, 0, 0);
    idle();
    rst = 1'b0;
    push_exp("post_rst", 0, 32, 33, 96, 0, 0, 0, 0);
    idle();
    push_exp("post_rst2", 0, 32, 33, 96, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_free_list_mw
`default_nettype wire
